dmi_req_bridge: RTL and testbench

Transaction-level bridge that sits directly upstream of the core's DMI register port. It accepts debug-transport requests (address, data, op) over a valid/ready handshake and drives a single-cycle `dmi_reg_en` access into the core. It captures `dmi_reg_rdata` after a fixed read latency and returns a RISC-V-debug-style response (data, op status) over a second valid/ready handshake. It also generates the `dmi_hard_reset` pulse.

---
 rtl/dmi_req_bridge_if.sv | 28 ++
 rtl/dmi_req_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_dmi_req_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_req_bridge_if.sv
// Request/response handshake bundle between a debug transport and dmi_req_bridge.
// The master side issues requests and consumes responses; the bridge is the slave.
interface dmi_req_bridge_if;

  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;     // 0=nop, 1=read, 2=write, 3=reserved

  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op;     // 0=success, 2=failed, 3=busy

  modport master (
    output req_valid, req_addr, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_op
  );

endinterface

// File: rtl/dmi_req_bridge.sv
// dmi_req_bridge: turns debug-transport requests into single-cycle accesses on
// the core's DMI register port and returns RISC-V-debug-style responses.
//
// Optional feature macro: RV_DMI_BRIDGE_STICKY_BUSY_EN
//   defined   - the request port is always ready; requests arriving while a
//               transaction is in flight are dropped and set a sticky busy flag,
//               later requests are answered with op=3 until dmi_reset.
//   undefined - the request port is ready only when idle; busy is tied low and
//               dmi_reset is ignored.
//
// RD_LAT (0..3) is the core's read latency from dmi_reg_en to valid rdata.
module dmi_req_bridge #(
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  dmi_req_bridge_if.slave        bus,
  input  logic                   dmi_reset,
  input  logic                   hard_reset_req,
  output logic                   busy,
  output logic                   dmi_reg_en,
  output logic                   dmi_reg_wr_en,
  output logic [6:0]             dmi_reg_addr,
  output logic [31:0]            dmi_reg_wdata,
  input  logic [31:0]            dmi_reg_rdata,
  output logic                   dmi_hard_reset
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RSP_OK     = 2'd0;
  localparam logic [1:0] RSP_FAILED = 2'd2;
  localparam logic [1:0] RSP_BUSY   = 2'd3;

  // Value of the wait counter on the final WAIT cycle (WAIT lasts RD_LAT cycles).
  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  wait_cnt;
  logic        hard_q;

  // Latched request and response registers
  logic        wr_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  rsp_op_q;
  logic [31:0] rsp_data_q;

  // Per-cycle decisions from the FSM
  logic        req_ready_int;
  logic        accept;
  logic        busy_hit;
  logic        capture;
  logic        latch_req;
  logic        load_rsp;
  logic [1:0]  rsp_op_nxt;

  assign accept        = bus.req_valid & req_ready_int;
  assign bus.req_ready = req_ready_int;

`ifdef RV_DMI_BRIDGE_STICKY_BUSY_EN
  logic busy_q;
  logic drop;

  // Always ready; a hard reset cycle (or rst) is the only time requests are refused.
  assign req_ready_int = ~rst & ~hard_reset_req;

  // A request that lands while a transaction is in flight has nowhere to go.
  assign drop = accept & (state != IDLE);

  // A dmi_reset in the same cycle as an idle accept lets that request through.
  assign busy_hit = busy_q & ~dmi_reset;

  // Sticky busy flag: set by dropped requests, cleared by dmi_reset or hard reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (hard_reset_req) begin
      busy_q <= 1'b0;
    end else if (drop) begin
      busy_q <= 1'b1;
    end else if (dmi_reset) begin
      busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
`else
  logic unused_dmi_reset;

  // Without sticky busy the port simply back-pressures until the bridge is idle.
  assign req_ready_int    = ~rst & ~hard_reset_req & (state == IDLE);
  assign busy_hit         = 1'b0;
  assign busy             = 1'b0;
  assign unused_dmi_reset = dmi_reset;
`endif

  // State register, read-wait counter and the delayed hard-reset pulse
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      hard_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT && state_nxt == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      hard_q   <= hard_reset_req;
    end
  end

  // Next-state logic and per-cycle strobes; hard reset overrides everything
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_nxt  = state;
    capture    = 1'b0;
    latch_req  = 1'b0;
    load_rsp   = 1'b0;
    rsp_op_nxt = RSP_OK;
    dmi_reg_en = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          load_rsp = 1'b1;
          if (busy_hit) begin
            rsp_op_nxt = RSP_BUSY;
            state_nxt  = RESP;
          end else begin
            case (bus.req_op)
              OP_READ, OP_WRITE: begin
                latch_req = 1'b1;
                state_nxt = ISSUE;
              end
              OP_NOP: begin
                state_nxt = RESP;
              end
              default: begin
                rsp_op_nxt = RSP_FAILED;
                state_nxt  = RESP;
              end
            endcase
          end
        end
      end

      ISSUE: begin
        dmi_reg_en = 1'b1;
        if (wr_q) begin
          state_nxt = RESP;
        end else if (RD_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abandon whatever was in flight: no access, no capture, no new request.
    if (hard_reset_req) begin
      state_nxt  = IDLE;
      capture    = 1'b0;
      latch_req  = 1'b0;
      load_rsp   = 1'b0;
      dmi_reg_en = 1'b0;
    end
  end

  // Request latch and response registers; rsp_data moves only on read captures
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      addr_q     <= 7'd0;
      wdata_q    <= 32'd0;
      rsp_op_q   <= RSP_OK;
      rsp_data_q <= 32'd0;
    end else begin
      if (latch_req) begin
        wr_q    <= (bus.req_op == OP_WRITE);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_data;
      end
      if (load_rsp) begin
        rsp_op_q <= rsp_op_nxt;
      end
      if (capture) begin
        rsp_data_q <= dmi_reg_rdata;
      end
    end
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_data   = rsp_data_q;
  assign dmi_reg_wr_en  = dmi_reg_en & wr_q;
  assign dmi_reg_addr   = addr_q;
  assign dmi_reg_wdata  = wdata_q;
  assign dmi_hard_reset = hard_q;

endmodule

// File: tb/tb_dmi_req_bridge.sv
// Testbench for dmi_req_bridge: directed table, hand-written corner sequences
// and random transactions checked against a transaction-level model.
// Instance A uses RD_LAT=1, instance B uses RD_LAT=3 (hard-reset-in-WAIT case).
module tb_dmi_req_bridge;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

`ifdef RV_DMI_BRIDGE_STICKY_BUSY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sel_b;
  logic drv_valid;
  logic drv_rsp_ready;
  logic [6:0]  drv_addr;
  logic [31:0] drv_data;
  logic [1:0]  drv_op;
  logic drv_dmi_reset;
  logic hr_a;
  logic hr_b;
  logic core_init;

  dmi_req_bridge_if bus_a ();
  dmi_req_bridge_if bus_b ();

  assign bus_a.req_valid = drv_valid & ~sel_b;
  assign bus_a.rsp_ready = drv_rsp_ready & ~sel_b;
  assign bus_a.req_addr  = drv_addr;
  assign bus_a.req_data  = drv_data;
  assign bus_a.req_op    = drv_op;
  assign bus_b.req_valid = drv_valid & sel_b;
  assign bus_b.rsp_ready = drv_rsp_ready & sel_b;
  assign bus_b.req_addr  = drv_addr;
  assign bus_b.req_data  = drv_data;
  assign bus_b.req_op    = drv_op;

  logic        busy_a, en_a, wr_a, hard_a;
  logic [6:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        busy_b, en_b, wr_b, hard_b;
  logic [6:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;

  dmi_req_bridge #(.RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dmi_reset(drv_dmi_reset), .hard_reset_req(hr_a),
    .busy(busy_a), .dmi_reg_en(en_a), .dmi_reg_wr_en(wr_a), .dmi_reg_addr(addr_a),
    .dmi_reg_wdata(wdata_a), .dmi_reg_rdata(rdata_a), .dmi_hard_reset(hard_a)
  );

  dmi_req_bridge #(.RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dmi_reset(drv_dmi_reset), .hard_reset_req(hr_b),
    .busy(busy_b), .dmi_reg_en(en_b), .dmi_reg_wr_en(wr_b), .dmi_reg_addr(addr_b),
    .dmi_reg_wdata(wdata_b), .dmi_reg_rdata(rdata_b), .dmi_hard_reset(hard_b)
  );

  // Observed outputs of whichever instance is selected
  logic        m_req_ready, m_rsp_valid, m_en, m_wr, m_hard, m_busy;
  logic [1:0]  m_rsp_op;
  logic [31:0] m_rsp_data, m_wdata;
  logic [6:0]  m_addr;
  assign m_req_ready = sel_b ? bus_b.req_ready : bus_a.req_ready;
  assign m_rsp_valid = sel_b ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign m_rsp_op    = sel_b ? bus_b.rsp_op    : bus_a.rsp_op;
  assign m_rsp_data  = sel_b ? bus_b.rsp_data  : bus_a.rsp_data;
  assign m_en        = sel_b ? en_b    : en_a;
  assign m_wr        = sel_b ? wr_b    : wr_a;
  assign m_addr      = sel_b ? addr_b  : addr_a;
  assign m_wdata     = sel_b ? wdata_b : wdata_a;
  assign m_hard      = sel_b ? hard_b  : hard_a;
  assign m_busy      = sel_b ? busy_b  : busy_a;

  function automatic logic [31:0] init_val(input logic [6:0] a);
    if (a == 7'h11) return 32'h0000_0C82;
    return {a, 1'b0, a, 1'b1, 16'hA5A5};
  endfunction

  // Core A: register file, read data valid exactly one cycle after the strobe,
  // garbage at every other cycle so a mistimed capture is visible.
  logic [31:0] core_regs [128];
  always @(posedge clk) begin
    if (core_init) begin
      for (int i = 0; i < 128; i++) core_regs[i] <= init_val(7'(i));
    end else if (en_a && wr_a) begin
      core_regs[addr_a] <= wdata_a;
    end
    rdata_a <= (en_a && !wr_a) ? core_regs[addr_a] : $urandom;
  end

  // Core B: three-stage read pipeline, data = 0xCAFE_0000 | addr
  logic [32:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= (en_b && !wr_b) ? {1'b1, 32'hCAFE_0000 | 32'(addr_b)} : 33'd0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2][32] ? pipe_b[2][31:0] : 32'hDEAD_BEEF;

  // Transaction-level reference model of bridge A
  logic [31:0] model_regs [128];
  logic [31:0] last_read;

  task automatic model_step(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                            output logic [1:0] e_op, output logic [31:0] e_data,
                            output int e_lat, output logic e_acc);
    case (op)
      OP_RD:   begin last_read = model_regs[addr]; e_op = 2'd0; e_lat = 2 + LAT_A; e_acc = 1'b1; end
      OP_WR:   begin model_regs[addr] = data;     e_op = 2'd0; e_lat = 2;         e_acc = 1'b1; end
      OP_NOP:  begin e_op = 2'd0; e_lat = 1; e_acc = 1'b0; end
      default: begin e_op = 2'd2; e_lat = 1; e_acc = 1'b0; end
    endcase
    e_data = last_read;
  endtask

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".req_ready"}, 32'(m_req_ready), 32'd0);
    check({tag, ".rsp_valid"}, 32'(m_rsp_valid), 32'd0);
    check({tag, ".rsp_op"},    32'(m_rsp_op),    32'd0);
    check({tag, ".rsp_data"},  m_rsp_data,       32'd0);
    check({tag, ".reg_en"},    32'(m_en),        32'd0);
    check({tag, ".wr_en"},     32'(m_wr),        32'd0);
    check({tag, ".addr"},      32'(m_addr),      32'd0);
    check({tag, ".wdata"},     m_wdata,          32'd0);
    check({tag, ".hard"},      32'(m_hard),      32'd0);
    check({tag, ".busy"},      32'(m_busy),      32'd0);
  endtask

  // One complete transaction on the selected instance, starting from idle.
  task automatic do_txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                        input logic [31:0] data, input int hold, input logic [1:0] exp_op,
                        input logic [31:0] exp_data, input int exp_lat, input logic exp_acc);
    int waited;
    int k;
    int en_cnt;
    logic seen;
    @(negedge clk);
    drv_valid = 1'b1; drv_op = op; drv_addr = addr; drv_data = data;
    #1;
    waited = 0;
    while (!m_req_ready && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check({tag, ".accepted"}, 32'(waited < 20), 32'd1);
    if (waited >= 20) begin
      drv_valid = 1'b0;
      return;
    end
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    k = 1; en_cnt = 0; seen = 1'b0;
    while (k <= 12) begin
      if (m_en) begin
        en_cnt++;
        check({tag, ".en_cycle"}, 32'(k), 32'd1);
        check({tag, ".en_wr"}, 32'(m_wr), 32'(op == OP_WR));
        check({tag, ".en_addr"}, 32'(m_addr), 32'(addr));
        if (op == OP_WR) check({tag, ".en_wdata"}, m_wdata, data);
      end
      if (m_rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1; k++;
    end
    check({tag, ".latency"}, seen ? 32'(k) : 32'd0, 32'(exp_lat));
    check({tag, ".accesses"}, 32'(en_cnt), exp_acc ? 32'd1 : 32'd0);
    if (!seen) return;
    check({tag, ".rsp_op"}, 32'(m_rsp_op), 32'(exp_op));
    check({tag, ".rsp_data"}, m_rsp_data, exp_data);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, ".hold_valid"}, 32'(m_rsp_valid), 32'd1);
      check({tag, ".hold_op"}, 32'(m_rsp_op), 32'(exp_op));
      check({tag, ".hold_data"}, m_rsp_data, exp_data);
      check({tag, ".hold_req_ready"}, 32'(m_req_ready), 32'(STICKY));
    end
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    drv_rsp_ready = 1'b0;
    #1;
    check({tag, ".after_valid"}, 32'(m_rsp_valid), 32'd0);
    check({tag, ".after_ready"}, 32'(m_req_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          hold;
    logic [1:0]  exp_op;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_acc;
  } vec_t;

  vec_t vecs [6];
  int   wk;
  int   hard_cnt;
  int   rsp_cnt;

  initial begin
    logic [1:0]  e_op;
    logic [31:0] e_data;
    int          e_lat;
    logic        e_acc;
    logic [1:0]  r_op;
    logic [6:0]  r_addr;
    logic [31:0] r_data;

    rst = 1'b1; core_init = 1'b1; sel_b = 1'b0;
    drv_valid = 1'b0; drv_rsp_ready = 1'b0; drv_addr = 7'd0; drv_data = 32'd0; drv_op = OP_NOP;
    drv_dmi_reset = 1'b0; hr_a = 1'b0; hr_b = 1'b0;
    for (int i = 0; i < 128; i++) model_regs[i] = init_val(7'(i));
    last_read = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0; core_init = 1'b0;
    #1;
    check("reset.ready_after", 32'(m_req_ready), 32'd1);

    // Directed table: read, write, reserved, nop, read-back, held response
    vecs[0] = '{OP_RD,  7'h11, 32'h0,         0, 2'd0, 32'h0000_0C82, 3, 1'b1};
    vecs[1] = '{OP_WR,  7'h10, 32'h8000_0001, 0, 2'd0, 32'h0000_0C82, 2, 1'b1};
    vecs[2] = '{OP_RSV, 7'h22, 32'h5555_AAAA, 0, 2'd2, 32'h0000_0C82, 1, 1'b0};
    vecs[3] = '{OP_NOP, 7'h05, 32'h0,         0, 2'd0, 32'h0000_0C82, 1, 1'b0};
    vecs[4] = '{OP_RD,  7'h10, 32'h0,         0, 2'd0, 32'h8000_0001, 3, 1'b1};
    vecs[5] = '{OP_RD,  7'h11, 32'h0,         5, 2'd0, 32'h0000_0C82, 3, 1'b1};
    for (int v = 0; v < 6; v++) begin
      model_step(vecs[v].op, vecs[v].addr, vecs[v].data, e_op, e_data, e_lat, e_acc);
      do_txn($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].hold,
             vecs[v].exp_op, vecs[v].exp_data, vecs[v].exp_lat, vecs[v].exp_acc);
    end

`ifdef RV_DMI_BRIDGE_STICKY_BUSY_EN
    // Request arriving while a read response is held: dropped, sets busy
    @(negedge clk);
    drv_valid = 1'b1; drv_op = OP_RD; drv_addr = 7'h11;
    #1;
    check("drop.first_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    wk = 0;
    while (!m_rsp_valid && wk < 12) begin
      @(negedge clk); #1; wk++;
    end
    check("drop.resp_reached", 32'(m_rsp_valid), 32'd1);
    drv_valid = 1'b1; drv_op = OP_WR; drv_addr = 7'h10; drv_data = 32'h1234_5678;
    #1;
    check("drop.ready_in_resp", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    check("drop.busy_set", 32'(m_busy), 32'd1);
    check("drop.rsp_still_valid", 32'(m_rsp_valid), 32'd1);
    check("drop.rsp_data", m_rsp_data, 32'h0000_0C82);
    check("drop.no_access", 32'(m_en), 32'd0);
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    drv_rsp_ready = 1'b0;
    model_step(OP_RD, 7'h11, 32'h0, e_op, e_data, e_lat, e_acc);
    do_txn("busy_answer", OP_RD, 7'h10, 32'h0, 0, 2'd3, 32'h0000_0C82, 1, 1'b0);
`endif

    // dmi_reset pulse leaves busy clear (clears it with sticky busy, ignored otherwise)
    @(negedge clk);
    drv_dmi_reset = 1'b1;
    @(negedge clk);
    drv_dmi_reset = 1'b0;
    #1;
    check("dmi_reset.busy", 32'(m_busy), 32'd0);
    model_step(OP_RD, 7'h10, 32'h0, e_op, e_data, e_lat, e_acc);
    do_txn("after_dmi_reset", OP_RD, 7'h10, 32'h0, 0, e_op, e_data, e_lat, e_acc);

    // Random transactions against the model
    for (int t = 0; t < 40; t++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 7) == 0) ? 7'h11 : 7'($urandom_range(0, 7));
      r_data = $urandom;
      model_step(r_op, r_addr, r_data, e_op, e_data, e_lat, e_acc);
      do_txn($sformatf("rnd%0d", t), r_op, r_addr, r_data, $urandom_range(0, 2),
             e_op, e_data, e_lat, e_acc);
    end

    // Hard reset during WAIT on the RD_LAT=3 instance
    @(negedge clk);
    sel_b = 1'b1;
    drv_valid = 1'b1; drv_op = OP_RD; drv_addr = 7'h05;
    #1;
    check("hr.accept_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    check("hr.issue_en", 32'(m_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    hr_b = 1'b1;
    #1;
    check("hr.ready_blocked", 32'(m_req_ready), 32'd0);
    check("hr.no_pulse_yet", 32'(m_hard), 32'd0);
    @(negedge clk);
    hr_b = 1'b0;
    #1;
    check("hr.pulse", 32'(m_hard), 32'd1);
    check("hr.rsp_dropped", 32'(m_rsp_valid), 32'd0);
    check("hr.idle_ready", 32'(m_req_ready), 32'd1);
    hard_cnt = 0; rsp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      hard_cnt += int'(m_hard);
      rsp_cnt  += int'(m_rsp_valid);
    end
    check("hr.pulse_width", 32'(hard_cnt), 32'd0);
    check("hr.no_response", 32'(rsp_cnt), 32'd0);
    do_txn("hr.next_read", OP_RD, 7'h05, 32'h0, 1, 2'd0, 32'hCAFE_0005, 2 + LAT_B, 1'b1);
    @(negedge clk);
    sel_b = 1'b0;

    // rst asserted while a response is pending
    @(negedge clk);
    drv_valid = 1'b1; drv_op = OP_RD; drv_addr = 7'h11;
    #1;
    check("rst.accept_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    wk = 0;
    while (!m_rsp_valid && wk < 12) begin
      @(negedge clk); #1; wk++;
    end
    check("rst.resp_reached", 32'(m_rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_cleared("rst_mid");
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(m_req_ready), 32'd1);
    last_read = 32'd0;
    model_step(OP_NOP, 7'h00, 32'h0, e_op, e_data, e_lat, e_acc);
    do_txn("rst.nop_after", OP_NOP, 7'h00, 32'h0, 0, e_op, e_data, e_lat, e_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
